// File: rtl/mem_write_buffer.sv
// Posted write buffer between the data cache memory port and main memory.
// Stores are queued in a circular FIFO and drained in push order over a
// req/ack handshake. Loads look up pending stores by address: the youngest
// matching word store is forwarded, a youngest matching byte store is
// flagged as a conflict so the load stalls instead of reading stale memory.
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   wr_en_i/addr/data/byte_op  store from the cache; dropped while full_o
//   full_o, empty_o   occupancy flags (count == DEPTH / count == 0)
//   rd_addr_i         load address for the forwarding lookup
//   fwd_hit_o/data_o  youngest match is a word store, and its data
//   fwd_conflict_o    youngest match is a byte store
//   mem_req_o/addr/data/byte_op  registered head write toward memory
//   mem_ack_i         memory accepted the head write this cycle
module mem_write_buffer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             wr_byte_op_i,
  output logic             full_o,
  output logic             empty_o,
  input  logic [WIDTH-1:0] rd_addr_i,
  output logic             fwd_hit_o,
  output logic [WIDTH-1:0] fwd_data_o,
  output logic             fwd_conflict_o,
  output logic             mem_req_o,
  output logic [WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0] mem_data_o,
  output logic             mem_byte_op_o,
  input  logic             mem_ack_i
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FullCount = (PW+1)'(DEPTH);

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  logic [WIDTH-1:0] addr_q [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] byte_q;
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    head_q, tail_q;
  logic [PW:0]      count_q, count_d;
  state_e           state_q;

  logic             push, pop;
  logic [PW-1:0]    nxt_idx;
  logic [WIDTH-1:0] nxt_addr, nxt_data;
  logic             nxt_byte;

  assign full_o  = (count_q == FullCount);
  assign empty_o = (count_q == '0);

  // full_o comes from the pre-edge count, so a push while full is dropped
  // even when a pop happens on the same edge.
  assign push = wr_en_i && !full_o;
  assign pop  = mem_req_o && mem_ack_i;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Entry that becomes head after a pop. When only one entry remains and a
  // push lands in that slot on the same edge, take it from the write port.
  always_comb begin
    nxt_idx = head_q + 1'b1;
    if (push && (nxt_idx == tail_q)) begin
      nxt_addr = wr_addr_i;
      nxt_data = wr_data_i;
      nxt_byte = wr_byte_op_i;
    end else begin
      nxt_addr = addr_q[nxt_idx];
      nxt_data = data_q[nxt_idx];
      nxt_byte = byte_q[nxt_idx];
    end
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      byte_q  <= '0;
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      if (push) begin
        addr_q[tail_q]  <= wr_addr_i;
        data_q[tail_q]  <= wr_data_i;
        byte_q[tail_q]  <= wr_byte_op_i;
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  // Drain FSM with registered memory-side outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      mem_req_o     <= 1'b0;
      mem_addr_o    <= '0;
      mem_data_o    <= '0;
      mem_byte_op_o <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (count_q != '0) begin
            state_q       <= StReq;
            mem_req_o     <= 1'b1;
            mem_addr_o    <= addr_q[head_q];
            mem_data_o    <= data_q[head_q];
            mem_byte_op_o <= byte_q[head_q];
          end
        end
        StReq: begin
          if (mem_ack_i) begin
            if (count_d != '0) begin
              // Back-to-back: next head is presented on the following cycle.
              mem_addr_o    <= nxt_addr;
              mem_data_o    <= nxt_data;
              mem_byte_op_o <= nxt_byte;
            end else begin
              state_q   <= StIdle;
              mem_req_o <= 1'b0;
            end
          end
        end
        default: begin
          state_q   <= StIdle;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

  // Forwarding lookup: walk oldest to youngest so the youngest match wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx            = '0;
    fwd_hit_o      = 1'b0;
    fwd_conflict_o = 1'b0;
    fwd_data_o     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (valid_q[idx] && (addr_q[idx] == rd_addr_i)) begin
        if (byte_q[idx]) begin
          fwd_hit_o      = 1'b0;
          fwd_conflict_o = 1'b1;
          fwd_data_o     = '0;
        end else begin
          fwd_hit_o      = 1'b1;
          fwd_conflict_o = 1'b0;
          fwd_data_o     = data_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_write_buffer.sv
// Self-checking bench for mem_write_buffer. A monitor keeps a queue of
// accepted stores (its own model of occupancy) and compares every write the
// DUT hands to memory against the queue head; directed sequences cover
// reset, latency, fill/drop, forwarding and random wrap-around traffic.
module tb_mem_write_buffer;

  localparam int W = 32;
  localparam int D = 4;

  typedef struct packed {
    logic [W-1:0] addr;
    logic [W-1:0] data;
    logic         bop;
  } wr_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic [W-1:0] wr_addr, wr_data;
  logic         wr_bop;
  logic         full, empty;
  logic [W-1:0] rd_addr;
  logic         fwd_hit, fwd_conflict;
  logic [W-1:0] fwd_data;
  logic         mem_req, mem_bop, mem_ack;
  logic [W-1:0] mem_addr, mem_data;

  mem_write_buffer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .wr_en_i        (wr_en),
    .wr_addr_i      (wr_addr),
    .wr_data_i      (wr_data),
    .wr_byte_op_i   (wr_bop),
    .full_o         (full),
    .empty_o        (empty),
    .rd_addr_i      (rd_addr),
    .fwd_hit_o      (fwd_hit),
    .fwd_data_o     (fwd_data),
    .fwd_conflict_o (fwd_conflict),
    .mem_req_o      (mem_req),
    .mem_addr_o     (mem_addr),
    .mem_data_o     (mem_data),
    .mem_byte_op_o  (mem_bop),
    .mem_ack_i      (mem_ack)
  );

  always #5 clk = ~clk;

  wr_t sq[$];
  wr_t exp_e;
  int  n_checks = 0;
  int  n_errors = 0;
  int  n_writes = 0;
  int  n_pushes = 0;
  int  mon_sz;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor runs 1 ns before each rising edge with the inputs already settled.
  always @(negedge clk) begin
    #4;
    if (!rst) begin
      mon_sz = sq.size();
      check("full_flag", full, mon_sz == D);
      check("empty_flag", empty, mon_sz == 0);
      if (mem_req && mem_ack) begin
        check("wr_pending", mon_sz != 0, 1);
        if (mon_sz != 0) begin
          exp_e = sq.pop_front();
          check("wr_addr", mem_addr, exp_e.addr);
          check("wr_data", mem_data, exp_e.data);
          check("wr_bop", mem_bop, exp_e.bop);
          n_writes++;
        end
      end
      if (wr_en && mon_sz < D) begin
        sq.push_back('{addr: wr_addr, data: wr_data, bop: wr_bop});
        n_pushes++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic set_wr(input logic en, input logic [W-1:0] a, input logic [W-1:0] d,
                        input logic b);
    wr_en   = en;
    wr_addr = a;
    wr_data = d;
    wr_bop  = b;
  endtask

  task automatic drain(input string tag);
    int guard;
    guard   = 0;
    mem_ack = 1'b1;
    while (!empty && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check(tag, empty, 1);
    mem_ack = 1'b0;
  endtask

  initial begin
    int w0;
    int base;
    int guard;
    int k;
    wr_t st[10];

    rst = 1'b1;
    set_wr(1'b0, '0, '0, 1'b0);
    rd_addr = '0;
    mem_ack = 1'b0;
    #1;
    check("rst_req", mem_req, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", mem_data, 0);
    check("rst_bop", mem_bop, 0);
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_fwd", fwd_hit, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single store, ack one cycle after the request appears.
    set_wr(1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    set_wr(1'b0, '0, '0, 1'b0);
    check("t2_req_k", mem_req, 0);
    check("t2_not_empty", empty, 0);
    @(negedge clk);
    check("t2_req_k1", mem_req, 1);
    check("t2_addr", mem_addr, 32'h100);
    check("t2_data", mem_data, 32'hDEAD_BEEF);
    @(negedge clk);
    check("t2_req_hold", mem_req, 1);
    check("t2_addr_hold", mem_addr, 32'h100);
    check("t2_data_hold", mem_data, 32'hDEAD_BEEF);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("t2_req_done", mem_req, 0);
    check("t2_empty_done", empty, 1);

    // Fill with ack low; fifth store must be dropped. Then drain back to back.
    for (int i = 0; i < 5; i++) begin
      set_wr(1'b1, 32'h300 + 32'(i * 4), 32'hA0 + 32'(i), 1'b0);
      @(negedge clk);
    end
    set_wr(1'b0, '0, '0, 1'b0);
    check("t3_full", full, 1);
    check("t3_req", mem_req, 1);
    w0      = n_writes;
    mem_ack = 1'b1;
    repeat (4) @(negedge clk);
    mem_ack = 1'b0;
    check("t3_writes", n_writes - w0, 4);
    check("t3_empty", empty, 1);
    check("t3_req_off", mem_req, 0);

    // Forwarding: youngest word store wins, byte store turns it into a conflict.
    set_wr(1'b1, 32'h200, 32'h11, 1'b0);
    @(negedge clk);
    set_wr(1'b1, 32'h200, 32'h22, 1'b0);
    rd_addr = 32'h200;
    #1;
    check("t4_hit_old", fwd_hit, 1);
    check("t4_data_old", fwd_data, 32'h11);
    @(negedge clk);
    set_wr(1'b1, 32'h200, 32'h33, 1'b1);
    #1;
    check("t4_hit", fwd_hit, 1);
    check("t4_data", fwd_data, 32'h22);
    check("t4_noconf", fwd_conflict, 0);
    @(negedge clk);
    set_wr(1'b0, '0, '0, 1'b0);
    #1;
    check("t4_conf", fwd_conflict, 1);
    check("t4_conf_hit", fwd_hit, 0);
    check("t4_conf_data", fwd_data, 0);
    rd_addr = 32'h204;
    #1;
    check("t4_miss_hit", fwd_hit, 0);
    check("t4_miss_conf", fwd_conflict, 0);
    @(negedge clk);
    drain("t4_drain");

    // Reset in the middle of a request with three entries queued.
    for (int i = 0; i < 3; i++) begin
      set_wr(1'b1, 32'h500 + 32'(i * 4), 32'h5500 + 32'(i), 1'b0);
      @(negedge clk);
    end
    set_wr(1'b0, '0, '0, 1'b0);
    check("t1_req_before", mem_req, 1);
    #2;
    rst = 1'b1;
    sq.delete();
    #1;
    check("t1_req_drop", mem_req, 0);
    check("t1_empty", empty, 1);
    rd_addr = 32'h504;
    #1;
    check("t1_fwd_hit", fwd_hit, 0);
    check("t1_fwd_conf", fwd_conflict, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t1_req_after", mem_req, 0);

    // Random traffic: 10 stores, random ack gaps, pointers wrap.
    for (int i = 0; i < 10; i++) begin
      st[i].addr = 32'h400 + 32'($urandom_range(0, 7) * 4);
      st[i].data = $urandom;
      st[i].bop  = ($urandom_range(0, 3) == 0);
    end
    base  = n_pushes;
    w0    = n_writes;
    guard = 0;
    while ((n_pushes - base) < 10 && guard < 200) begin
      k = n_pushes - base;
      set_wr($urandom_range(0, 3) != 0, st[k].addr, st[k].data, st[k].bop);
      mem_ack = $urandom_range(0, 1) == 1;
      @(negedge clk);
      guard++;
    end
    set_wr(1'b0, '0, '0, 1'b0);
    check("t5_budget", guard < 200, 1);
    drain("t5_drain");
    check("t5_writes", n_writes - w0, 10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
